// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing front-end (alu_ctrl).
// Holds the ALU op codes, the op legality check, the FSM state type and
// the bit positions of the {C,Z,N} flag register.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Only these six codes produce a writeback; every other code is rejected.
  function automatic logic op_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_ctrl_rf.sv
// Register file for alu_ctrl: NREGS x DATA_W, two asynchronous read ports,
// one instruction writeback port and one direct load port. When both write
// ports hit the same entry on the same edge, the instruction writeback wins.
module alu_ctrl_rf
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   rd_addr_a_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  input  logic [RA_W-1:0]   rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wr_we_i,
  input  logic [RA_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ld_we_i,
  input  logic [RA_W-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  logic [DATA_W-1:0] rf_q [NREGS];

  assign rd_data_a_o = rf_q[rd_addr_a_i];
  assign rd_data_b_o = rf_q[rd_addr_b_i];

  // Storage update: the load is applied first so a same-address writeback overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (ld_we_i) begin
        rf_q[ld_addr_i] <= ld_data_i;
      end
      if (wr_we_i) begin
        rf_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing front-end for the external 4-bit combinational ALU.
// Accepts one register-to-register instruction per two cycles, drives the
// ALU from registered operands, then writes the result back and latches
// the {C,Z,N} flags. Optional build macro ALU_CTRL_IMM_EN adds an
// immediate B operand (in_use_imm / in_imm).
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
`ifdef ALU_CTRL_IMM_EN
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
`endif
  input  logic              ld_valid,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags_q,
  output logic              illegal_op
);

  state_e            state_q, state_d;
  logic              accept;
  logic              wb_we;
  logic              exec_illegal;
  logic [3:0]        op_q;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] b_d;
  logic              wb_valid_q;
  logic [RA_W-1:0]   wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              illegal_op_q;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  alu_ctrl_rf #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_a_i (in_rs1),
    .rd_data_a_o (rs1_data),
    .rd_addr_b_i (in_rs2),
    .rd_data_b_o (rs2_data),
    .wr_we_i     (wb_we),
    .wr_addr_i   (rd_q),
    .wr_data_i   (alu_out),
    .ld_we_i     (ld_valid),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data)
  );

  // B operand source: register file, or the immediate when that build option is on.
`ifdef ALU_CTRL_IMM_EN
  assign b_d = in_use_imm ? in_imm : rs2_data;
`else
  assign b_d = rs2_data;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake and writeback strobes; EXEC always lasts one cycle.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    accept       = 1'b0;
    wb_we        = 1'b0;
    exec_illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_we        = op_legal(op_q);
        exec_illegal = ~op_legal(op_q);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch; these registers also drive the ALU and hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      rd_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= in_op;
      rd_q <= in_rd;
      a_q  <= rs1_data;
      b_q  <= b_d;
    end
  end

  // Writeback report, illegal-op pulse and flag capture at the closing EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      illegal_op_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      wb_valid_q   <= wb_we;
      illegal_op_q <= exec_illegal;
      if (wb_we) begin
        wb_rd_q        <= rd_q;
        wb_data_q      <= alu_out;
        flags_q[FLG_C] <= alu_carry;
        flags_q[FLG_Z] <= alu_zero;
        flags_q[FLG_N] <= alu_neg;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign illegal_op = illegal_op_q;

endmodule
